brent_kung_adder: RTL and testbench



---
 rtl/bk_pkg.sv | 6 +
 rtl/bk_black_cell.sv | 12 +
 rtl/brent_kung_adder.sv | 110 +++++++++++
 tb/tb_brent_kung_adder.sv | 117 +++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// bk_pkg: shared width and tree-depth constants for the Brent-Kung adder
package bk_pkg;
    localparam int WIDTH  = 64;
    localparam int LEVELS = 6;
    localparam int STAGES = 2 * LEVELS - 1;
endpackage

// File: rtl/bk_black_cell.sv
// bk_black_cell: prefix operator combining a high (G, P) group with the adjacent low group
module bk_black_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;
endmodule

// File: rtl/brent_kung_adder.sv
// brent_kung_adder: registered 64-bit adder with carry-in, carries from a Brent-Kung prefix tree
module brent_kung_adder
    import bk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic A_1,  A_2,  A_3,  A_4,  A_5,  A_6,  A_7,  A_8,
    input  logic A_9,  A_10, A_11, A_12, A_13, A_14, A_15, A_16,
    input  logic A_17, A_18, A_19, A_20, A_21, A_22, A_23, A_24,
    input  logic A_25, A_26, A_27, A_28, A_29, A_30, A_31, A_32,
    input  logic A_33, A_34, A_35, A_36, A_37, A_38, A_39, A_40,
    input  logic A_41, A_42, A_43, A_44, A_45, A_46, A_47, A_48,
    input  logic A_49, A_50, A_51, A_52, A_53, A_54, A_55, A_56,
    input  logic A_57, A_58, A_59, A_60, A_61, A_62, A_63, A_64,
    input  logic B_1,  B_2,  B_3,  B_4,  B_5,  B_6,  B_7,  B_8,
    input  logic B_9,  B_10, B_11, B_12, B_13, B_14, B_15, B_16,
    input  logic B_17, B_18, B_19, B_20, B_21, B_22, B_23, B_24,
    input  logic B_25, B_26, B_27, B_28, B_29, B_30, B_31, B_32,
    input  logic B_33, B_34, B_35, B_36, B_37, B_38, B_39, B_40,
    input  logic B_41, B_42, B_43, B_44, B_45, B_46, B_47, B_48,
    input  logic B_49, B_50, B_51, B_52, B_53, B_54, B_55, B_56,
    input  logic B_57, B_58, B_59, B_60, B_61, B_62, B_63, B_64,
    input  logic C_0,
    output logic S_1,  S_2,  S_3,  S_4,  S_5,  S_6,  S_7,  S_8,
    output logic S_9,  S_10, S_11, S_12, S_13, S_14, S_15, S_16,
    output logic S_17, S_18, S_19, S_20, S_21, S_22, S_23, S_24,
    output logic S_25, S_26, S_27, S_28, S_29, S_30, S_31, S_32,
    output logic S_33, S_34, S_35, S_36, S_37, S_38, S_39, S_40,
    output logic S_41, S_42, S_43, S_44, S_45, S_46, S_47, S_48,
    output logic S_49, S_50, S_51, S_52, S_53, S_54, S_55, S_56,
    output logic S_57, S_58, S_59, S_60, S_61, S_62, S_63, S_64,
    output logic C_out
);
    logic [WIDTH-1:0] a_v, b_v, s_d, s_q;
    logic             c_out_d, c_out_q;
    logic [WIDTH:0]   g [0:STAGES];
    logic [WIDTH:0]   p [0:STAGES];
    logic             unused_p;

    assign a_v = {A_64, A_63, A_62, A_61, A_60, A_59, A_58, A_57,
                  A_56, A_55, A_54, A_53, A_52, A_51, A_50, A_49,
                  A_48, A_47, A_46, A_45, A_44, A_43, A_42, A_41,
                  A_40, A_39, A_38, A_37, A_36, A_35, A_34, A_33,
                  A_32, A_31, A_30, A_29, A_28, A_27, A_26, A_25,
                  A_24, A_23, A_22, A_21, A_20, A_19, A_18, A_17,
                  A_16, A_15, A_14, A_13, A_12, A_11, A_10, A_9,
                  A_8,  A_7,  A_6,  A_5,  A_4,  A_3,  A_2,  A_1};
    assign b_v = {B_64, B_63, B_62, B_61, B_60, B_59, B_58, B_57,
                  B_56, B_55, B_54, B_53, B_52, B_51, B_50, B_49,
                  B_48, B_47, B_46, B_45, B_44, B_43, B_42, B_41,
                  B_40, B_39, B_38, B_37, B_36, B_35, B_34, B_33,
                  B_32, B_31, B_30, B_29, B_28, B_27, B_26, B_25,
                  B_24, B_23, B_22, B_21, B_20, B_19, B_18, B_17,
                  B_16, B_15, B_14, B_13, B_12, B_11, B_10, B_9,
                  B_8,  B_7,  B_6,  B_5,  B_4,  B_3,  B_2,  B_1};
    assign {S_64, S_63, S_62, S_61, S_60, S_59, S_58, S_57,
            S_56, S_55, S_54, S_53, S_52, S_51, S_50, S_49,
            S_48, S_47, S_46, S_45, S_44, S_43, S_42, S_41,
            S_40, S_39, S_38, S_37, S_36, S_35, S_34, S_33,
            S_32, S_31, S_30, S_29, S_28, S_27, S_26, S_25,
            S_24, S_23, S_22, S_21, S_20, S_19, S_18, S_17,
            S_16, S_15, S_14, S_13, S_12, S_11, S_10, S_9,
            S_8,  S_7,  S_6,  S_5,  S_4,  S_3,  S_2,  S_1} = s_q;
    assign C_out = c_out_q;

    // Position 0 carries the carry-in as a pure generate.
    assign g[0] = {a_v & b_v, C_0};
    assign p[0] = {a_v ^ b_v, 1'b0};

    // Stages 1..LEVELS reduce with span 2^s; the remaining stages fill in the gaps at halving distances.
    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        localparam int  D  = (s <= LEVELS) ? (1 << (s - 1)) : (1 << (STAGES - s));
        localparam bit  UP = (s <= LEVELS);
        for (genvar i = 0; i <= WIDTH; i++) begin : g_node
            if (UP ? ((i + 1) % (2 * D) == 0) : (i >= 2 * D && (i + 1) % (2 * D) == D)) begin : g_cell
                bk_black_cell u_cell (
                    .g_hi(g[s-1][i]),
                    .p_hi(p[s-1][i]),
                    .g_lo(g[s-1][i-D]),
                    .p_lo(p[s-1][i-D]),
                    .g   (g[s][i]),
                    .p   (p[s][i])
                );
            end else begin : g_pass
                assign g[s][i] = g[s-1][i];
                assign p[s][i] = p[s-1][i];
            end
        end
    end

    // Every final group spans down to position 0, so its propagate is never consumed.
    assign unused_p = ^p[STAGES];

    // Sum bit k uses the carry into k, which is the group generate of everything below it.
    always_comb begin
        s_d     = p[0][WIDTH:1] ^ g[STAGES][WIDTH-1:0];
        c_out_d = g[STAGES][WIDTH];
    end

    // Output register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
        end
    end
endmodule

// File: tb/tb_brent_kung_adder.sv
// tb_brent_kung_adder: scoreboard bench comparing registered sums against a 65-bit golden add
module tb_brent_kung_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a_v = '0;
    logic [63:0] b_v = '0;
    logic        c_in = 1'b0;
    wire  [63:0] s_v;
    wire         c_out;
    logic [64:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    brent_kung_adder dut (
        .clk(clk), .rst_n(rst_n), .C_0(c_in), .C_out(c_out),
        .A_1(a_v[0]),   .A_2(a_v[1]),   .A_3(a_v[2]),   .A_4(a_v[3]),   .A_5(a_v[4]),   .A_6(a_v[5]),   .A_7(a_v[6]),   .A_8(a_v[7]),
        .A_9(a_v[8]),   .A_10(a_v[9]),  .A_11(a_v[10]), .A_12(a_v[11]), .A_13(a_v[12]), .A_14(a_v[13]), .A_15(a_v[14]), .A_16(a_v[15]),
        .A_17(a_v[16]), .A_18(a_v[17]), .A_19(a_v[18]), .A_20(a_v[19]), .A_21(a_v[20]), .A_22(a_v[21]), .A_23(a_v[22]), .A_24(a_v[23]),
        .A_25(a_v[24]), .A_26(a_v[25]), .A_27(a_v[26]), .A_28(a_v[27]), .A_29(a_v[28]), .A_30(a_v[29]), .A_31(a_v[30]), .A_32(a_v[31]),
        .A_33(a_v[32]), .A_34(a_v[33]), .A_35(a_v[34]), .A_36(a_v[35]), .A_37(a_v[36]), .A_38(a_v[37]), .A_39(a_v[38]), .A_40(a_v[39]),
        .A_41(a_v[40]), .A_42(a_v[41]), .A_43(a_v[42]), .A_44(a_v[43]), .A_45(a_v[44]), .A_46(a_v[45]), .A_47(a_v[46]), .A_48(a_v[47]),
        .A_49(a_v[48]), .A_50(a_v[49]), .A_51(a_v[50]), .A_52(a_v[51]), .A_53(a_v[52]), .A_54(a_v[53]), .A_55(a_v[54]), .A_56(a_v[55]),
        .A_57(a_v[56]), .A_58(a_v[57]), .A_59(a_v[58]), .A_60(a_v[59]), .A_61(a_v[60]), .A_62(a_v[61]), .A_63(a_v[62]), .A_64(a_v[63]),
        .B_1(b_v[0]),   .B_2(b_v[1]),   .B_3(b_v[2]),   .B_4(b_v[3]),   .B_5(b_v[4]),   .B_6(b_v[5]),   .B_7(b_v[6]),   .B_8(b_v[7]),
        .B_9(b_v[8]),   .B_10(b_v[9]),  .B_11(b_v[10]), .B_12(b_v[11]), .B_13(b_v[12]), .B_14(b_v[13]), .B_15(b_v[14]), .B_16(b_v[15]),
        .B_17(b_v[16]), .B_18(b_v[17]), .B_19(b_v[18]), .B_20(b_v[19]), .B_21(b_v[20]), .B_22(b_v[21]), .B_23(b_v[22]), .B_24(b_v[23]),
        .B_25(b_v[24]), .B_26(b_v[25]), .B_27(b_v[26]), .B_28(b_v[27]), .B_29(b_v[28]), .B_30(b_v[29]), .B_31(b_v[30]), .B_32(b_v[31]),
        .B_33(b_v[32]), .B_34(b_v[33]), .B_35(b_v[34]), .B_36(b_v[35]), .B_37(b_v[36]), .B_38(b_v[37]), .B_39(b_v[38]), .B_40(b_v[39]),
        .B_41(b_v[40]), .B_42(b_v[41]), .B_43(b_v[42]), .B_44(b_v[43]), .B_45(b_v[44]), .B_46(b_v[45]), .B_47(b_v[46]), .B_48(b_v[47]),
        .B_49(b_v[48]), .B_50(b_v[49]), .B_51(b_v[50]), .B_52(b_v[51]), .B_53(b_v[52]), .B_54(b_v[53]), .B_55(b_v[54]), .B_56(b_v[55]),
        .B_57(b_v[56]), .B_58(b_v[57]), .B_59(b_v[58]), .B_60(b_v[59]), .B_61(b_v[60]), .B_62(b_v[61]), .B_63(b_v[62]), .B_64(b_v[63]),
        .S_1(s_v[0]),   .S_2(s_v[1]),   .S_3(s_v[2]),   .S_4(s_v[3]),   .S_5(s_v[4]),   .S_6(s_v[5]),   .S_7(s_v[6]),   .S_8(s_v[7]),
        .S_9(s_v[8]),   .S_10(s_v[9]),  .S_11(s_v[10]), .S_12(s_v[11]), .S_13(s_v[12]), .S_14(s_v[13]), .S_15(s_v[14]), .S_16(s_v[15]),
        .S_17(s_v[16]), .S_18(s_v[17]), .S_19(s_v[18]), .S_20(s_v[19]), .S_21(s_v[20]), .S_22(s_v[21]), .S_23(s_v[22]), .S_24(s_v[23]),
        .S_25(s_v[24]), .S_26(s_v[25]), .S_27(s_v[26]), .S_28(s_v[27]), .S_29(s_v[28]), .S_30(s_v[29]), .S_31(s_v[30]), .S_32(s_v[31]),
        .S_33(s_v[32]), .S_34(s_v[33]), .S_35(s_v[34]), .S_36(s_v[35]), .S_37(s_v[36]), .S_38(s_v[37]), .S_39(s_v[38]), .S_40(s_v[39]),
        .S_41(s_v[40]), .S_42(s_v[41]), .S_43(s_v[42]), .S_44(s_v[43]), .S_45(s_v[44]), .S_46(s_v[45]), .S_47(s_v[46]), .S_48(s_v[47]),
        .S_49(s_v[48]), .S_50(s_v[49]), .S_51(s_v[50]), .S_52(s_v[51]), .S_53(s_v[52]), .S_54(s_v[53]), .S_55(s_v[54]), .S_56(s_v[55]),
        .S_57(s_v[56]), .S_58(s_v[57]), .S_59(s_v[58]), .S_60(s_v[59]), .S_61(s_v[60]), .S_62(s_v[61]), .S_63(s_v[62]), .S_64(s_v[63])
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one operand set, push its golden sum, then compare the result one edge later.
    task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [64:0] e;
        a_v  = a;
        b_v  = b;
        c_in = c;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {64'd0, c});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 65'd1, 65'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {c_out, s_v}, e);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        a_v  = 64'hDEAD_BEEF_1234_5678;
        b_v  = 64'h0F0F_0F0F_F0F0_F0F0;
        c_in = 1'b1;
        #2;
        check("reset_hold", {c_out, s_v}, 65'd0);
        rst_n = 1'b1;
        step("first_after_reset", 64'h3333_3333_3333_3333, 64'h3333_3333_3333_3331, 1'b0);
        check("vec_3333_sum", {c_out, s_v}, {1'b0, 64'h6666_6666_6666_6664});
        step("vec_b333", 64'hB333_3333_3333_3335, 64'hB333_3333_3333_333C, 1'b0);
        check("vec_b333_sum", {c_out, s_v}, {1'b1, 64'h6666_6666_6666_6671});
        step("ones_plus_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        check("ones_plus_cin_lit", {c_out, s_v}, {1'b1, 64'd0});
        step("ones_no_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        check("ones_no_cin_lit", {c_out, s_v}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        step("max_max_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("max_max_cin_lit", {c_out, s_v}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        step("zero_cin", 64'd0, 64'd0, 1'b1);
        for (int k = 0; k < 64; k++) begin
            logic [63:0] one;
            one = 64'd1;
            step("carry_chain", (one << k) - one, one, 1'b0);
            step("carry_chain_cin", (one << k) - one, 64'd0, 1'b1);
        end
        for (int n = 0; n < 10000; n++) begin
            step("random", rnd64(), rnd64(), 1'($urandom_range(0, 1)));
            if (n == 5000) begin
                a_v   = rnd64() | 64'd1;
                b_v   = rnd64();
                rst_n = 1'b0;
                #1;
                check("mid_reset_async", {c_out, s_v}, 65'd0);
                @(posedge clk);
                #1;
                check("mid_reset_hold", {c_out, s_v}, 65'd0);
                rst_n = 1'b1;
                step("after_mid_reset", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
                check("after_mid_reset_lit", {c_out, s_v}, {1'b1, 64'd0});
            end
        end
        check("scoreboard_drained", 65'(exp_q.size()), 65'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
